// File: rtl/fnd_apb_pkg.sv
// Shared types and register map for the two-port APB arbiter in front of the FND peripheral.
package fnd_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [3:0] FND_FCR_ADDR = 4'h0;
    localparam logic [3:0] FND_FDR_ADDR = 4'h4;
    localparam logic [3:0] FND_FPR_ADDR = 4'h8;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick; the last_grant register lives in the parent.
module rr_arbiter_2
    import fnd_apb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    input  logic       i_enable,
    output logic [1:0] o_grant
);

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            if (i_req == 2'b11) begin
                o_grant = i_last_grant ? 2'b01 : 2'b10;
            end else begin
                o_grant = i_req;
            end
        end
    end

endmodule

// File: rtl/fnd_apb_arbiter.sv
// Two-requester APB master for the FND register file: round-robin grant, SETUP/ACCESS
// sequencing, PREADY timeout, and a registered per-requester done pulse with read data.
module fnd_apb_arbiter
    import fnd_apb_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ack,
    output logic              req0_done,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ack,
    output logic              req1_done,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic [1:0]        o_dbg_state
);

    localparam int                CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t            r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        w_grant;
    logic              w_enable;
    logic              w_win;

    // Handshake: reqN_valid is held with a stable payload until reqN_ack; ack is a
    // combinational one-cycle pulse in an IDLE cycle and the payload is latched on that
    // edge. Dropping valid before ack withdraws the request with no side effect.
    assign w_enable = (r_state == IDLE) && !PRESET;

    rr_arbiter_2 u_arb (
        .i_req        ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant),
        .i_enable     (w_enable),
        .o_grant      (w_grant)
    );

    assign req0_ack    = w_grant[0];
    assign req1_ack    = w_grant[1];
    assign w_win       = w_grant[1];
    assign o_dbg_state = r_state;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            PADDR        <= '0;
            PWDATA       <= '0;
            PWRITE       <= 1'b0;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            req0_done    <= 1'b0;
            req1_done    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        PADDR        <= w_win ? req1_addr  : req0_addr;
                        PWDATA       <= w_win ? req1_wdata : req0_wdata;
                        PWRITE       <= w_win ? req1_write : req0_write;
                        PSEL         <= 1'b1;
                        PENABLE      <= 1'b0;
                        r_owner      <= w_win;
                        r_last_grant <= w_win;
                        r_cnt        <= '0;
                        r_state      <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    // Completion and timeout share the exit path; only the payload differs.
                    if (PREADY || (r_cnt == CNT_LAST)) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_err   <= !PREADY;
                        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
                        req0_done <= !r_owner;
                        req1_done <= r_owner;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fnd_apb_arbiter.sv
// Randomized bench for fnd_apb_arbiter: APB slave model plus a transaction-timeline
// reference (grant order, phase windows, done timing, read data from a shadow register file).
module tb_fnd_apb_arbiter;
    import fnd_apb_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          req0_valid, req0_write, req1_valid, req1_write;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          req0_ack, req0_done, req1_ack, req1_done;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PWRITE, PSEL, PENABLE, PREADY;
    logic [1:0]    dbg_state;

    fnd_apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_done(req1_done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 PCLK = ~PCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // requester driver state
    logic        drv_v[2];
    logic        drv_w[2];
    logic [3:0]  drv_a[2];
    logic [31:0] drv_d[2];
    int          rem[2];
    int          prob;
    bit          wr_only;
    int          wait_lo, wait_hi;
    int          stale_mode;
    bit          rst_drv;

    // slave model
    logic [31:0] slv_mem[4];
    int          acc_n;
    int          cur_wait;
    int          wait_q[$];

    // reference model
    logic [31:0] ref_mem[4];
    int          m_free, m_last;
    bit          t_active, t_write, t_err;
    int          t_g, t_alen, t_own;
    logic [3:0]  t_addr;
    logic [31:0] t_wdata;
    logic [31:0] exp_q[$];
    bit          exp_err_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        t_active = 1'b0;
        m_free   = 0;
        m_last   = 1;
        acc_n    = 0;
        exp_q.delete();
        exp_err_q.delete();
        wait_q.delete();
    endtask

    task automatic run_cycle();
        logic [1:0] exp_ack, exp_done;
        bit         psel_exp, pen_exp;
        int         idx, win, w;
        @(negedge PCLK);
        cyc++;
        PRESET = rst_drv;
        for (int r = 0; r < 2; r++) begin
            if (!drv_v[r] && rem[r] > 0 && $urandom_range(0, 99) < prob) begin
                drv_v[r] = 1'b1;
                drv_w[r] = wr_only ? 1'b1 : 1'($urandom_range(0, 1));
                drv_a[r] = {2'($urandom_range(0, 3)), 2'b00};
                drv_d[r] = $urandom;
            end
        end
        req0_valid = drv_v[0]; req0_write = drv_w[0]; req0_addr = drv_a[0]; req0_wdata = drv_d[0];
        req1_valid = drv_v[1]; req1_write = drv_w[1]; req1_addr = drv_a[1]; req1_wdata = drv_d[1];
        // slave: PREADY after cur_wait ACCESS cycles; optional junk PREADY outside ACCESS
        if (PSEL && PENABLE) begin
            acc_n++;
            if (acc_n == 1) cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            PREADY = (acc_n > cur_wait);
        end else begin
            acc_n  = 0;
            PREADY = (stale_mode == 2) ? 1'b1 : (stale_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        idx    = int'(PADDR[3:2]);
        PRDATA = (PSEL && !PWRITE) ? ((idx == 3) ? 32'h0 : slv_mem[idx]) : $urandom;
        if (PSEL && PENABLE && PREADY && PWRITE && idx != 3) slv_mem[idx] = PWDATA;
        #1;
        exp_ack = 2'b00; exp_done = 2'b00; psel_exp = 1'b0; pen_exp = 1'b0;
        if (!rst_drv && t_active) begin
            psel_exp = (cyc >= t_g + 1) && (cyc <= t_g + 1 + t_alen);
            pen_exp  = (cyc >= t_g + 2) && (cyc <= t_g + 1 + t_alen);
            if (cyc == t_g + 2 + t_alen) begin
                exp_done[t_own] = 1'b1;
                t_active = 1'b0;
                if (t_write && !t_err && t_addr != 4'hC) ref_mem[t_addr[3:2]] = t_wdata;
            end
        end
        check_val("done", {req1_done, req0_done}, exp_done);
        check_val("psel", PSEL, psel_exp);
        check_val("penable", PENABLE, pen_exp);
        if (psel_exp) begin
            check_val("paddr", PADDR, t_addr);
            check_val("pwdata", PWDATA, t_wdata);
            check_val("pwrite", PWRITE, t_write);
        end
        if (rst_drv) begin
            check_val("rst_paddr", PADDR, 0);
            check_val("rst_pwdata", PWDATA, 0);
            check_val("rst_pwrite", PWRITE, 0);
            check_val("rst_rdata", rsp_rdata, 0);
            check_val("rst_err", rsp_err, 0);
            check_val("rst_state", dbg_state, IDLE);
        end
        if (exp_done != 2'b00) begin
            if (exp_q.size() > 0) begin
                check_val("rsp_rdata", rsp_rdata, exp_q.pop_front());
                check_val("rsp_err", rsp_err, exp_err_q.pop_front());
            end else begin
                check_val("exp_q_empty", exp_q.size(), 1);
            end
        end
        // arbitration at transaction level
        if (!rst_drv && cyc >= m_free && (drv_v[0] || drv_v[1])) begin
            win = (drv_v[0] && drv_v[1]) ? ((m_last == 1) ? 0 : 1) : (drv_v[0] ? 0 : 1);
            exp_ack[win] = 1'b1;
            w = $urandom_range(wait_lo, wait_hi);
            wait_q.push_back(w);
            t_active = 1'b1; t_g = cyc; t_own = win;
            t_addr = drv_a[win]; t_wdata = drv_d[win]; t_write = drv_w[win];
            t_err  = (w + 1 > TO);
            t_alen = t_err ? TO : w + 1;
            m_free = cyc + 2 + t_alen;
            m_last = win;
            if (t_err || t_write) exp_q.push_back(32'h0);
            else exp_q.push_back((t_addr == 4'hC) ? 32'h0 : ref_mem[t_addr[3:2]]);
            exp_err_q.push_back(t_err);
        end
        check_val("ack", {req1_ack, req0_ack}, exp_ack);
        if (req0_ack) begin drv_v[0] = 1'b0; if (rem[0] > 0) rem[0]--; end
        if (req1_ack) begin drv_v[1] = 1'b0; if (rem[1] > 0) rem[1]--; end
    endtask

    task automatic set_req(input int r, input logic wr, input logic [3:0] a, input logic [31:0] d);
        drv_v[r] = 1'b1; drv_w[r] = wr; drv_a[r] = a; drv_d[r] = d;
    endtask

    task automatic drain();
        int guard = 0;
        while ((t_active || drv_v[0] || drv_v[1] || rem[0] > 0 || rem[1] > 0) && guard < 3000) begin
            run_cycle();
            guard++;
        end
        check_val("drain_idle", {29'h0, t_active, drv_v[1], drv_v[0]}, 0);
    endtask

    initial begin
        int guard;
        PRESET = 1'b1; rst_drv = 1'b1;
        prob = 0; wr_only = 1'b0; wait_lo = 1; wait_hi = 1; stale_mode = 0;
        for (int i = 0; i < 2; i++) begin
            drv_v[i] = 1'b0; drv_w[i] = 1'b0; drv_a[i] = 4'h0; drv_d[i] = 32'h0; rem[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin slv_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        cur_wait = 0;
        PREADY = 1'b0; PRDATA = 32'h0;
        model_reset();

        // reset with both requesters pending: acks held low, req0 wins the first tie
        set_req(0, 1'b1, FND_FDR_ADDR, 32'd1234);
        set_req(1, 1'b1, FND_FPR_ADDR, 32'h5);
        repeat (3) run_cycle();
        rst_drv = 1'b0;
        drain();
        check_val("fnd_fdr", slv_mem[1], 32'd1234);

        // read-back of FPR by requester 1, unmapped offset round trip by requester 0
        set_req(1, 1'b0, FND_FPR_ADDR, 32'h0);
        drain();
        check_val("readback", rsp_rdata, 32'h5);
        set_req(0, 1'b1, 4'hC, 32'hDEAD_BEEF);
        drain();
        set_req(0, 1'b0, 4'hC, 32'h0);
        drain();

        // contention: both always valid, writes only
        prob = 100; wr_only = 1'b1; rem[0] = 10; rem[1] = 10;
        drain();

        // random traffic with variable wait states and junk PREADY outside ACCESS
        prob = 40; wr_only = 1'b0; wait_lo = 0; wait_hi = 4; stale_mode = 1;
        rem[0] = 40; rem[1] = 40;
        drain();

        // timeout: PREADY never asserted
        prob = 50; wait_lo = 1000; wait_hi = 1000; stale_mode = 0;
        rem[0] = 2; rem[1] = 2;
        drain();

        // just below, at and past the timeout boundary
        wait_lo = 14; wait_hi = 16; rem[0] = 4; rem[1] = 4;
        drain();

        // withdrawal while busy, with PREADY forced high in IDLE/SETUP
        prob = 0; wait_lo = 1; wait_hi = 1; stale_mode = 2;
        set_req(1, 1'b1, FND_FCR_ADDR, 32'h77);
        run_cycle();
        set_req(0, 1'b1, FND_FDR_ADDR, 32'h99);
        run_cycle();
        drv_v[0] = 1'b0;
        drain();
        check_val("withdraw_fdr", slv_mem[1], ref_mem[1]);

        // reset in the first ACCESS cycle
        stale_mode = 0; wait_lo = 3; wait_hi = 3;
        set_req(0, 1'b1, FND_FCR_ADDR, 32'hAA);
        guard = 0;
        run_cycle();
        while (!(t_active && cyc == t_g + 2) && guard < 10) begin
            run_cycle();
            guard++;
        end
        check_val("reach_access", dbg_state, ACCESS);
        #2;
        PRESET = 1'b1; rst_drv = 1'b1;
        #1;
        check_val("rst_async_psel", PSEL, 0);
        check_val("rst_async_penable", PENABLE, 0);
        check_val("rst_async_done", {req1_done, req0_done}, 0);
        model_reset();
        drv_v[0] = 1'b0; drv_v[1] = 1'b0;
        repeat (2) run_cycle();
        set_req(0, 1'b0, FND_FCR_ADDR, 32'h0);
        set_req(1, 1'b0, FND_FDR_ADDR, 32'h0);
        rst_drv = 1'b0;
        drain();

        for (int i = 0; i < 4; i++) check_val("mem_final", slv_mem[i], ref_mem[i]);
        check_val("end_state", dbg_state, IDLE);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
